// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square-root unit.
// The root width sets both the iteration count and the remainder width.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One root bit per iteration, so the root width is also the iteration count.
  function automatic int calc_root_w(input int width, input int fbits);
    return width / 2 + fbits;
  endfunction

  function automatic bit params_ok(input int width, input int fbits);
    return (width >= 4) && (width % 2 == 0) && (fbits >= 0);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One shift-subtract digit of the square-root recurrence (combinational).
// ac carries one guard bit above the remainder so the trial sign is its MSB.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int REM_W = 9
) (
  input  logic [REM_W:0]   i_ac,
  input  logic [1:0]       i_xtop,
  input  logic [REM_W-2:0] i_q,
  output logic [REM_W:0]   o_ac,
  output logic [REM_W-2:0] o_q
);

  localparam int AC_W = REM_W + 1;
  localparam int Q_W  = REM_W - 1;

  logic [AC_W-1:0] w_ac_shift;
  logic [AC_W-1:0] w_test;
  logic            w_neg;
  logic            w_unused_ac_top;

  // The partial remainder never exceeds 2*q, so the two bits shifted out are always zero.
  assign w_unused_ac_top = ^i_ac[AC_W-1:AC_W-2];

  assign w_ac_shift = {i_ac[AC_W-3:0], i_xtop};
  assign w_test     = w_ac_shift - {i_q, 2'b01};
  assign w_neg      = w_test[AC_W-1];

  assign o_ac = w_neg ? w_ac_shift : w_test;
  assign o_q  = {i_q[Q_W-2:0], ~w_neg};

endmodule

// File: rtl/sqrt_iter_pipe.sv
// Iterative square root with valid/ready on both sides, one root bit per cycle.
// state | meaning: IDLE waiting for radicand; RUN iterating; DONE result held for consumer.
module sqrt_iter_pipe
  import sqrt_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int FBITS  = 0,
  localparam int ROOT_W = calc_root_w(WIDTH, FBITS),
  localparam int REM_W  = ROOT_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  rad,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] root,
  output logic [REM_W-1:0]  rem,
  output logic              busy
);

  localparam int ITER  = ROOT_W;
  localparam int AC_W  = REM_W + 1;
  localparam int X_W   = 2 * ROOT_W;
  localparam int CNT_W = $clog2(ITER) + 1;

  if (!params_ok(WIDTH, FBITS)) begin : g_bad_params
    $error("sqrt_iter_pipe: WIDTH must be even and >= 4, FBITS >= 0");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic              w_load;
  logic              w_last;
  logic [X_W-1:0]    r_x;
  logic [AC_W-1:0]   r_ac;
  logic [AC_W-1:0]   w_ac_next;
  logic [ROOT_W-1:0] r_q;
  logic [ROOT_W-1:0] w_q_next;
  logic [ROOT_W-1:0] r_root;
  logic [REM_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_cnt;

  sqrt_step #(.REM_W(REM_W)) u_step (
    .i_ac   (r_ac),
    .i_xtop (r_x[X_W-1 -: 2]),
    .i_q    (r_q),
    .o_ac   (w_ac_next),
    .o_q    (w_q_next)
  );

  assign w_last = (r_cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // in_ready follows out_ready only in DONE, so a result slot frees and refills in one edge.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    in_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_load       = 1'b1;
            w_state_next = RUN;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_ac   <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_root <= '0;
      r_rem  <= '0;
    end else if (w_load) begin
      r_x   <= X_W'(rad) << (2 * FBITS);
      r_ac  <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_x   <= r_x << 2;
      r_ac  <= w_ac_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_root <= w_q_next;
        r_rem  <= w_ac_next[REM_W-1:0];
      end
    end
  end

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign root      = r_root;
  assign rem       = r_rem;

endmodule
